mem_stage: RTL

- Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Accepts the execute-to-memory bus and the synchronous data-SRAM read data, which returns one cycle after the address is issued in execute.
- Extracts and sign/zero-extends sub-word load data and selects the final result.
- Forwards to writeback over the valid/allowin handshake and exports stall and forward information to decode.

---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/mem_stage_load_extract.sv | 41 ++++
 rtl/mem_stage.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline header for the memory stage: bus widths, load-type codes and
// the misaligned-load helper used when MS_ADEL_CHECK_EN is defined.
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 74;
   localparam int MS_TO_WS_BUS_WD = 70;

   typedef enum logic [2:0] {
      LD_LW  = 3'd0,
      LD_LB  = 3'd1,
      LD_LBU = 3'd2,
      LD_LH  = 3'd3,
      LD_LHU = 3'd4
   } ld_type_e;

   // Codes 5-7 behave as LW, so they share the word-alignment rule.
   function automatic logic is_misaligned(input logic [2:0] ld_type, input logic [1:0] addr);
      logic mis;
      case (ld_type)
         LD_LB, LD_LBU: mis = 1'b0;
         LD_LH, LD_LHU: mis = addr[0];
         default:       mis = (addr != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_stage_load_extract.sv
// Combinational sub-word extraction of a little-endian load word with
// sign or zero extension selected by ld_type.
module load_extract
   import mem_stage_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  ld_type,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the byte and halfword lanes, then extend according to load type.
   always_comb begin
      byte_sel = 8'h00;
      half_sel = 16'h0000;
      result   = word;
      case (addr)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         2'd3:    byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      if (addr[1]) begin
         half_sel = word[31:16];
      end else begin
         half_sel = word[15:0];
      end
      case (ld_type)
         LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  result = {24'h000000, byte_sel};
         LD_LH:   result = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  result = {16'h0000, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and writeback.
// Optional misaligned-load detection is enabled by defining MS_ADEL_CHECK_EN.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic                       ms_write_reg,
   output logic [4:0]                 ms_reg_dest,
   output logic [31:0]                ms_to_ds_bus
`ifdef MS_ADEL_CHECK_EN
   ,output logic                      ms_adel
`endif
);

   logic                       ms_valid_r;
   logic                       first_r;
   logic                       hold_valid_r;
   logic [31:0]                hold_data_r;
   logic [ES_TO_MS_BUS_WD-1:0] bus_r;

   logic        ms_ready_go;
   logic [2:0]  ld_type;
   logic        res_from_mem;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;
   logic [31:0] raw_word;
   logic [31:0] load_value;
   logic [31:0] final_result;
   logic        gr_we_eff;

   assign ms_ready_go  = 1'b1;
   assign ms_allowin   = !ms_valid_r || (ms_ready_go && ws_allowin);
   assign ld_type      = bus_r[73:71];
   assign res_from_mem = bus_r[70];
   assign gr_we        = bus_r[69];
   assign dest         = bus_r[68:64];
   assign alu_result   = bus_r[63:32];
   assign pc           = bus_r[31:0];

   // Stage valid, first-cycle flag and held SRAM data for stalled loads.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_r   <= 1'b0;
         first_r      <= 1'b0;
         hold_valid_r <= 1'b0;
      end else begin
         if (ms_allowin) begin
            ms_valid_r <= es_to_ms_valid;
         end
         first_r <= es_to_ms_valid && ms_allowin;
         if (ms_allowin) begin
            hold_valid_r <= 1'b0;
         end else if (ms_valid_r && first_r && !ws_allowin) begin
            hold_valid_r <= 1'b1;
         end
      end
   end

   // Data-path registers carry no reset; their contents are gated by the valids.
   always_ff @(posedge clk) begin
      if (es_to_ms_valid && ms_allowin) begin
         bus_r <= es_to_ms_bus;
      end
      if (ms_valid_r && first_r && !ws_allowin) begin
         hold_data_r <= data_sram_rdata;
      end
   end

   assign raw_word = hold_valid_r ? hold_data_r : data_sram_rdata;

   load_extract u_load_extract (
      .word    (raw_word),
      .addr    (alu_result[1:0]),
      .ld_type (ld_type),
      .result  (load_value)
   );

   // Result select and write-enable qualification.
   always_comb begin
      if (res_from_mem) begin
         final_result = load_value;
      end else begin
         final_result = alu_result;
      end
`ifdef MS_ADEL_CHECK_EN
      ms_adel   = ms_valid_r && res_from_mem && is_misaligned(ld_type, alu_result[1:0]);
      gr_we_eff = gr_we && !ms_adel;
`else
      gr_we_eff = gr_we;
`endif
   end

   assign ms_to_ws_valid = ms_valid_r && ms_ready_go;
   assign ms_to_ws_bus   = {gr_we_eff, dest, final_result, pc};
   assign ms_write_reg   = gr_we_eff && ms_valid_r;
   assign ms_reg_dest    = dest;
   assign ms_to_ds_bus   = final_result;

endmodule
